rst_mp: RTL

Parametrised multi-port register status table for the Tomasulo/ROB back end of risc_v_sp. It tracks which architectural registers wait on an in-flight ROB tag and answers source-operand tag lookups at dispatch. It clears entries from any of several common data buses in the same cycle, generates register-file write enables, keeps a live count of pending registers, and supports flush.

---
 rtl/rst_mp.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rst_mp.sv
// Register status table for the Tomasulo/ROB back end: tracks registers waiting on ROB tags,
// answers dispatch source lookups with a CDB bypass, and clears entries from several CDB ports.
module rst_mp #(
    parameter  int NUM_REGS  = 32,
    parameter  int TAG_W     = 6,
    parameter  int NUM_CDB   = 2,
    parameter  int HARD_ZERO = 1,
    localparam int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      disp_en,
    input  logic [ADDR_W-1:0]         disp_addr,
    input  logic [TAG_W-1:0]          disp_tag,
    input  logic [ADDR_W-1:0]         rs1_addr,
    input  logic [ADDR_W-1:0]         rs2_addr,
    output logic [TAG_W-1:0]          rs1_tag,
    output logic [TAG_W-1:0]          rs2_tag,
    output logic                      rs1_pending,
    output logic                      rs2_pending,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    output logic [NUM_CDB-1:0]        wb_en,
    output logic [NUM_CDB*ADDR_W-1:0] wb_addr,
    output logic [ADDR_W:0]           pending_cnt
);

    logic [NUM_REGS-1:0] pend_q;
    logic [TAG_W-1:0]    tag_q [NUM_REGS];

    logic [TAG_W-1:0]    ctag     [NUM_CDB];
    logic [NUM_CDB-1:0]  raw_en;
    logic [ADDR_W-1:0]   raw_addr [NUM_CDB];
    logic [NUM_REGS-1:0] clr;
    logic                disp_ok;
    logic [ADDR_W:0]     clr_cnt;
    logic [ADDR_W:0]     cnt_d;
    logic                rs1_byp;
    logic                rs2_byp;

    // Per-port raw match: scanning downward leaves the lowest-index hit as the winner.
    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        raw_en   = '0;
        raw_addr = '{default: '0};
        for (int k = 0; k < NUM_CDB; k++) begin
            ctag[k] = cdb_tag[k*TAG_W +: TAG_W];
            for (int i = NUM_REGS - 1; i >= 0; i--) begin
                if (cdb_valid[k] && pend_q[i] && tag_q[i] == ctag[k]) begin
                    raw_en[k]   = 1'b1;
                    raw_addr[k] = ADDR_W'(i);
                end
            end
        end
    end

    // A port whose tag was already claimed by a lower-numbered port stays silent.
    always_comb begin
        wb_en   = '0;
        wb_addr = '0;
        clr     = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            wb_en[k] = raw_en[k];
            for (int j = 0; j < k; j++) begin
                if (raw_en[j] && ctag[j] == ctag[k]) wb_en[k] = 1'b0;
            end
            if (wb_en[k]) begin
                wb_addr[k*ADDR_W +: ADDR_W] = raw_addr[k];
                clr[raw_addr[k]]            = 1'b1;
            end
        end
    end

    always_comb begin
        rs1_byp = 1'b0;
        rs2_byp = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (cdb_valid[k] && ctag[k] == tag_q[rs1_addr]) rs1_byp = 1'b1;
            if (cdb_valid[k] && ctag[k] == tag_q[rs2_addr]) rs2_byp = 1'b1;
        end
    end

    assign rs1_tag     = tag_q[rs1_addr];
    assign rs2_tag     = tag_q[rs2_addr];
    assign rs1_pending = pend_q[rs1_addr] && !rs1_byp;
    assign rs2_pending = pend_q[rs2_addr] && !rs2_byp;

    // A cleared entry that is re-renamed in the same cycle stays pending, so it is not counted.
    always_comb begin
        disp_ok = disp_en && !(HARD_ZERO != 0 && disp_addr == '0);
        clr_cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clr[i] && !(disp_ok && disp_addr == ADDR_W'(i))) clr_cnt = clr_cnt + 1'b1;
        end
        cnt_d = pending_cnt - clr_cnt;
        if (disp_ok && !pend_q[disp_addr]) cnt_d = cnt_d + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only; the table is small enough
    // that resetting every entry is cheap and makes flush and reset share one cleared state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            tag_q       <= '{default: '0};
            pending_cnt <= '0;
        end else if (flush) begin
            pend_q      <= '0;
            tag_q       <= '{default: '0};
            pending_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (disp_ok && disp_addr == ADDR_W'(i)) begin
                    pend_q[i] <= 1'b1;
                    tag_q[i]  <= disp_tag;
                end else if (clr[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
            pending_cnt <= cnt_d;
        end
    end

endmodule
